// File: rtl/flip_sequencer_if.sv
// Word-access port between flip_sequencer (master) and the wowi adapter (slave).
interface flip_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WORD_BYTES = 2,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                             st_read;
    logic                             st_write;
    logic [ADDR_WIDTH-1:0]            base_addr;
    logic [WORD_BYTES*DATA_WIDTH-1:0] write_data;
    logic [WORD_BYTES*DATA_WIDTH-1:0] read_data;
    logic                             flip_ready;
    logic                             wrt_done;

    modport master (
        output st_read, st_write, base_addr, write_data,
        input  read_data, flip_ready, wrt_done
    );

    modport slave (
        input  st_read, st_write, base_addr, write_data,
        output read_data, flip_ready, wrt_done
    );
endinterface

// File: rtl/flip_sequencer.sv
// Walks a rectangle of words, reading each, byte-reversing it and writing it back in place.
// Define FLIP_BITS_EN to also reverse the bits within each byte (full word bit reversal).
module flip_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WORD_BYTES = 2,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [3:0]            num_cols_i,
    input  logic [3:0]            num_rows_i,
    input  logic [ADDR_WIDTH-1:0] row_stride_i,
    flip_sequencer_if.master      bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            words_done_o
);
    localparam int unsigned WordWidth = WORD_BYTES * DATA_WIDTH;

    typedef enum logic [2:0] {StIdle, StRead, StGapR, StWrite, StGapW, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] row_base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] base_addr_q;
    logic [3:0]            cols_q;
    logic [3:0]            rows_q;
    logic [3:0]            col_q;
    logic [3:0]            row_q;
    logic                  st_read_q;
    logic                  st_write_q;
    logic                  busy_q;
    logic                  done_q;
    logic [7:0]            words_done_q;
    logic [WordWidth-1:0]  write_data_q;
    logic [WordWidth-1:0]  flipped;
    logic                  last_col;
    logic                  last_row;

    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
        for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
`ifdef FLIP_BITS_EN
            assign flipped[i*DATA_WIDTH+b] =
                bus.read_data[(WORD_BYTES-1-i)*DATA_WIDTH + DATA_WIDTH-1-b];
`else
            assign flipped[i*DATA_WIDTH+b] = bus.read_data[(WORD_BYTES-1-i)*DATA_WIDTH + b];
`endif
        end
    end

    assign last_col = (col_q == cols_q - 4'd1);
    assign last_row = (row_q == rows_q - 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            row_base_q   <= '0;
            stride_q     <= '0;
            base_addr_q  <= '0;
            cols_q       <= '0;
            rows_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            st_read_q    <= 1'b0;
            st_write_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            words_done_q <= '0;
            write_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        row_base_q   <= start_addr_i;
                        base_addr_q  <= start_addr_i;
                        stride_q     <= row_stride_i;
                        cols_q       <= num_cols_i;
                        rows_q       <= num_rows_i;
                        col_q        <= '0;
                        row_q        <= '0;
                        words_done_q <= '0;
                        if (num_cols_i == 4'd0 || num_rows_i == 4'd0) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            st_read_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (bus.flip_ready) begin
                        write_data_q <= flipped;
                        st_read_q    <= 1'b0;
                        state_q      <= StGapR;
                    end
                end
                StGapR: begin
                    st_write_q <= 1'b1;
                    state_q    <= StWrite;
                end
                StWrite: begin
                    if (bus.wrt_done) begin
                        st_write_q <= 1'b0;
                        if (words_done_q != 8'hFF) words_done_q <= words_done_q + 8'd1;
                        state_q <= StGapW;
                    end
                end
                StGapW: begin
                    if (last_col && last_row) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        // Next row restarts from the running row base; wrap mod 2^ADDR_WIDTH.
                        if (last_col) begin
                            col_q       <= '0;
                            row_q       <= row_q + 4'd1;
                            row_base_q  <= row_base_q + stride_q;
                            base_addr_q <= row_base_q + stride_q;
                        end else begin
                            col_q       <= col_q + 4'd1;
                            base_addr_q <= base_addr_q + ADDR_WIDTH'(WORD_BYTES);
                        end
                        st_read_q <= 1'b1;
                        state_q   <= StRead;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.st_read    = st_read_q;
    assign bus.st_write   = st_write_q;
    assign bus.base_addr  = base_addr_q;
    assign bus.write_data = write_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign words_done_o   = words_done_q;
endmodule

// File: tb/tb_flip_sequencer.sv
// Scoreboard bench for flip_sequencer: random rectangles against a byte-array reference model.
module tb_flip_sequencer;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int WB = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [3:0]    num_cols = '0;
    logic [3:0]    num_rows = '0;
    logic [AW-1:0] row_stride = '0;
    logic          busy;
    logic          done;
    logic [7:0]    words_done;

    flip_sequencer_if #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .ADDR_WIDTH(AW)) bus_if ();

    flip_sequencer #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .start_addr_i (start_addr),
        .num_cols_i   (num_cols),
        .num_rows_i   (num_rows),
        .row_stride_i (row_stride),
        .bus          (bus_if),
        .busy_o       (busy),
        .done_o       (done),
        .words_done_o (words_done)
    );

    always #5 clk = ~clk;

    logic [7:0]  bram [256];
    logic [7:0]  model_mem [256];
    logic [7:0]  rd_q [$];
    logic [7:0]  wa_q [$];
    logic [15:0] wd_q [$];
    int          done_q [$];
    int          total = 0;
    int          bad = 0;
    bit          done_seen = 0;
    bit          stall_mode = 0;
    bit          hang_write = 0;
    bit          noise = 0;
    int          cyc = 0;
    int          rrise = 0;
    int          rfall = 0;
    logic        prd = 0;
    logic        pwr = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] flip_word(input logic [15:0] w);
        logic [15:0] r;
`ifdef FLIP_BITS_EN
        r = {<<{w}};
`else
        r = {<<8{w}};
`endif
        return r;
    endfunction

    // Reference: walk the rectangle on a copy of memory, in order, recording expectations.
    task automatic issue_job(input logic [7:0] sa, input int nc, input int nr, input logic [7:0] st);
        int n = 0;
        logic [7:0] a, a1;
        logic [15:0] f;
        for (int i = 0; i < 256; i++) model_mem[i] = bram[i];
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                a  = 8'(int'(sa) + r * int'(st) + c * WB);
                a1 = a + 8'd1;
                f  = flip_word({model_mem[a1], model_mem[a]});
                rd_q.push_back(a);
                wa_q.push_back(a);
                wd_q.push_back(f);
                model_mem[a]  = f[7:0];
                model_mem[a1] = f[15:8];
                n++;
            end
        end
        done_q.push_back(n > 255 ? 255 : n);
        done_seen = 0;
        @(negedge clk);
        start_addr = sa;
        num_cols   = 4'(nc);
        num_rows   = 4'(nr);
        row_stride = st;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_addr = 8'($urandom);
        num_cols   = 4'($urandom);
        num_rows   = 4'($urandom);
        row_stride = 8'($urandom);
    endtask

    task automatic wait_job(output int lat);
        int k = 0;
        int errs = 0;
        while (!done_seen && k < 3000) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        check("done_arrived", int'(done_seen), 1);
        for (int i = 0; i < 256; i++) if (bram[i] !== model_mem[i]) errs++;
        check("bram_contents", errs, 0);
        check("queues_drained", rd_q.size() + wa_q.size() + done_q.size(), 0);
    endtask

    // Adapter model: random response latency, optional stall/hang, optional spurious strobes.
    initial begin
        logic [7:0] a, a1;
        int d;
        bus_if.flip_ready = 1'b0;
        bus_if.wrt_done   = 1'b0;
        bus_if.read_data  = '0;
        forever begin
            @(negedge clk);
            if (bus_if.st_read) begin
                d = stall_mode ? 5 : int'($urandom_range(0, 3));
                for (int k = 0; k < d && bus_if.st_read; k++) @(negedge clk);
                if (bus_if.st_read) begin
                    a  = bus_if.base_addr;
                    a1 = a + 8'd1;
                    bus_if.read_data  = {bram[a1], bram[a]};
                    bus_if.flip_ready = 1'b1;
                    @(negedge clk);
                    bus_if.flip_ready = 1'b0;
                    bus_if.read_data  = 16'($urandom);
                end
            end else if (bus_if.st_write) begin
                d = hang_write ? 100000 : int'($urandom_range(0, 3));
                for (int k = 0; k < d && bus_if.st_write; k++) @(negedge clk);
                if (bus_if.st_write) begin
                    a  = bus_if.base_addr;
                    a1 = a + 8'd1;
                    bram[a]  = bus_if.write_data[7:0];
                    bram[a1] = bus_if.write_data[15:8];
                    bus_if.wrt_done = 1'b1;
                    @(negedge clk);
                    bus_if.wrt_done = 1'b0;
                end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                bus_if.flip_ready = 1'b1;
                bus_if.wrt_done   = 1'b1;
                bus_if.read_data  = 16'($urandom);
                @(negedge clk);
                bus_if.flip_ready = 1'b0;
                bus_if.wrt_done   = 1'b0;
            end
        end
    end

    // Monitor: protocol rules plus scoreboard pops on each request edge and on done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                prd = 1'b0;
                pwr = 1'b0;
            end else begin
                check("rw_exclusive", int'(bus_if.st_read & bus_if.st_write), 0);
                if (bus_if.st_read && !prd) begin
                    rrise = cyc;
                    check("read_gap", int'(pwr), 0);
                    check("read_expected", int'(rd_q.size() > 0), 1);
                    if (rd_q.size() > 0) check("read_addr", bus_if.base_addr, rd_q.pop_front());
                end
                if (!bus_if.st_read && prd) begin
                    rfall = cyc;
                    check("read_release", int'(bus_if.flip_ready), 1);
                    if (stall_mode) check("stall_hold", cyc - rrise, 6);
                end
                if (bus_if.st_write && !pwr) begin
                    check("write_gap", int'(prd), 0);
                    check("gap_before_write", cyc - rfall, 1);
                    check("write_expected", int'(wa_q.size() > 0), 1);
                    if (wa_q.size() > 0) begin
                        check("write_addr", bus_if.base_addr, wa_q.pop_front());
                        check("write_data", bus_if.write_data, wd_q.pop_front());
                    end
                end
                if (!bus_if.st_write && pwr) check("write_release", int'(bus_if.wrt_done), 1);
                if (done) begin
                    done_seen = 1;
                    check("busy_at_done", int'(busy), 0);
                    check("done_expected", int'(done_q.size() > 0), 1);
                    if (done_q.size() > 0) check("words_done", words_done, done_q.pop_front());
                end
                prd = bus_if.st_read;
                pwr = bus_if.st_write;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        for (int i = 0; i < 256; i++) bram[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst_ctrl", {bus_if.st_read, bus_if.st_write, busy, done}, 0);
        check("rst_words", words_done, 0);
        check("rst_addr", bus_if.base_addr, 0);
        check("rst_wdata", bus_if.write_data, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single word with known bytes.
        bram[8'h10] = 8'h12;
        bram[8'h11] = 8'h34;
        issue_job(8'h10, 1, 1, 8'h00);
        check("busy_after_start", int'(busy), 1);
        wait_job(lat);
`ifdef FLIP_BITS_EN
        check("single_lo", bram[8'h10], 8'h2C);
        check("single_hi", bram[8'h11], 8'h48);
`else
        check("single_lo", bram[8'h10], 8'h34);
        check("single_hi", bram[8'h11], 8'h12);
`endif

        // Rectangle and address wrap.
        issue_job(8'h00, 3, 2, 8'h10);
        wait_job(lat);
        issue_job(8'hFE, 2, 1, 8'h00);
        wait_job(lat);

        // Empty rectangle: immediate done, no requests.
        issue_job(8'h40, 0, 5, 8'h10);
        wait_job(lat);
        check("empty_latency", int'(lat <= 1), 1);

        // Stalled adapter with starts pulsed while busy.
        stall_mode = 1;
        issue_job(8'h20, 2, 1, 8'h00);
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            start_addr = 8'h80;
            num_cols   = 4'd4;
            num_rows   = 4'd4;
            start      = 1'b1;
            @(negedge clk);
            start      = 1'b0;
            repeat (4) @(negedge clk);
        end
        wait_job(lat);
        stall_mode = 0;

        // Reset in the middle of a write.
        hang_write = 1;
        issue_job(8'h30, 2, 1, 8'h00);
        k = 0;
        while (!bus_if.st_write && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_write", int'(bus_if.st_write), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ctrl", {bus_if.st_read, bus_if.st_write, busy, done}, 0);
        check("midrst_words", words_done, 0);
        check("midrst_addr", bus_if.base_addr, 0);
        check("midrst_wdata", bus_if.write_data, 0);
        @(negedge clk);
        reset = 1'b0;
        hang_write = 0;
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        done_q.delete();
        @(negedge clk);
        issue_job(8'h30, 2, 2, 8'h08);
        wait_job(lat);

        // Random rectangles with spurious strobes outside READ/WRITE.
        noise = 1;
        for (int j = 0; j < 10; j++) begin
            issue_job(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      8'($urandom));
            wait_job(lat);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end
        noise = 0;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
